// File: rtl/cpu_pkg.sv
// Shared pipeline bus layouts and widths for the LoongArch five-stage core.
package cpu_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned REG_AW      = 5;
    localparam int unsigned EX_TO_MEM_W = 77;
    localparam int unsigned MEM_TO_WB_W = 72;
    localparam int unsigned MEM_TO_ID_W = 39;
    localparam int unsigned MEM_TO_EX_W = 2;

    // Field order is MSB first, matching the packed bus vectors.
    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic              res_from_mem;
        logic              rf_we;
        logic [REG_AW-1:0] rf_waddr;
        logic [XLEN-1:0]   alu_result;
        logic              ld_b;
        logic              ld_h;
        logic              ld_u;
        logic              mem_req;
        logic              excep_en;
        logic              ertn_flush;
    } ex_to_mem_t;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic              rf_we;
        logic [REG_AW-1:0] rf_waddr;
        logic [XLEN-1:0]   final_result;
        logic              excep_en;
        logic              ertn_flush;
    } mem_to_wb_t;

    typedef struct packed {
        logic              load_pending;
        logic              rf_we;
        logic [REG_AW-1:0] rf_waddr;
        logic [XLEN-1:0]   final_result;
    } mem_to_id_t;

    typedef struct packed {
        logic excep_en;
        logic ertn_flush;
    } mem_to_ex_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } mem_state_e;

endpackage

// File: rtl/load_align.sv
// Byte-lane alignment and sign/zero extension of load data.
module load_align
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0] raw_i,
    input  logic [1:0]      offset_i,
    input  logic            ld_b_i,
    input  logic            ld_h_i,
    input  logic            ld_u_i,
    output logic [XLEN-1:0] data_c
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = raw_i >> {offset_i, 3'b000};
        data_c  = shifted;
        if (ld_b_i) begin
            data_c = {{24{~ld_u_i & shifted[7]}}, shifted[7:0]};
        end else if (ld_h_i) begin
            data_c = {{16{~ld_u_i & shifted[15]}}, shifted[15:0]};
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: waits for data-SRAM responses, buffers load
// data across write-back stalls and drops responses orphaned by a flush.
module mem_stage
    import cpu_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ex_to_mem_valid,
    output logic                   mem_allowin,
    input  logic [EX_TO_MEM_W-1:0] ex_to_mem_bus,
    output logic [MEM_TO_EX_W-1:0] mem_to_ex_bus,
    output logic [MEM_TO_ID_W-1:0] mem_to_id_bus,
    input  logic                   wb_allowin,
    output logic                   mem_to_wb_valid,
    output logic [MEM_TO_WB_W-1:0] mem_to_wb_bus,
    input  logic                   data_sram_data_ok,
    input  logic [XLEN-1:0]        data_sram_rdata,
    input  logic                   flush
);

    mem_state_e      state_q, state_d;
    ex_to_mem_t      payload_q, payload_d, in_bus;
    logic [XLEN-1:0] buf_data_q, buf_data_d;
    logic [1:0]      discard_cnt_q, discard_cnt_d;

    logic            mem_valid, buf_valid, data_ok_cnt, ready_go;
    logic            accept, leave, capture, cnt_inc, cnt_dec;
    logic [XLEN-1:0] raw, load_data, final_result;
    mem_to_wb_t      wb_bus;
    mem_to_id_t      id_bus;
    mem_to_ex_t      ex_bus;

    assign in_bus = ex_to_mem_t'(ex_to_mem_bus);

    // A HOLD-state instruction that issued a request has its data in the buffer.
    assign mem_valid       = (state_q != S_EMPTY);
    assign buf_valid       = (state_q == S_HOLD) && payload_q.mem_req;
    assign data_ok_cnt     = data_sram_data_ok && (discard_cnt_q == 2'd0);
    assign ready_go        = !payload_q.mem_req || buf_valid || data_ok_cnt;
    assign mem_allowin     = !mem_valid || (ready_go && wb_allowin);
    assign mem_to_wb_valid = mem_valid && ready_go;

    assign accept  = ex_to_mem_valid && mem_allowin && !flush;
    assign leave   = mem_to_wb_valid && wb_allowin;
    assign capture = (state_q == S_WAIT) && data_ok_cnt && !wb_allowin;

    // Each in-flight request killed by flush leaves one response to swallow.
    assign cnt_inc = flush && (state_q == S_WAIT) && !data_ok_cnt;
    assign cnt_dec = data_sram_data_ok && (discard_cnt_q != 2'd0);

    always_comb begin
        state_d       = state_q;
        payload_d     = payload_q;
        buf_data_d    = buf_data_q;
        discard_cnt_d = discard_cnt_q;

        if (flush) begin
            state_d = S_EMPTY;
        end else if (accept) begin
            state_d   = in_bus.mem_req ? S_WAIT : S_HOLD;
            payload_d = in_bus;
        end else if (leave) begin
            state_d = S_EMPTY;
        end else if (capture) begin
            state_d    = S_HOLD;
            buf_data_d = data_sram_rdata;
        end

        if (cnt_inc && !cnt_dec && (discard_cnt_q != 2'd3)) begin
            discard_cnt_d = discard_cnt_q + 2'd1;
        end else if (cnt_dec && !cnt_inc) begin
            discard_cnt_d = discard_cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_EMPTY;
            payload_q     <= '0;
            buf_data_q    <= '0;
            discard_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            payload_q     <= payload_d;
            buf_data_q    <= buf_data_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end

    assign raw = buf_valid ? buf_data_q : data_sram_rdata;

    load_align u_load_align (
        .raw_i    (raw),
        .offset_i (payload_q.alu_result[1:0]),
        .ld_b_i   (payload_q.ld_b),
        .ld_h_i   (payload_q.ld_h),
        .ld_u_i   (payload_q.ld_u),
        .data_c   (load_data)
    );

    assign final_result = payload_q.res_from_mem ? load_data : payload_q.alu_result;

    always_comb begin
        wb_bus.pc           = payload_q.pc;
        wb_bus.rf_we        = payload_q.rf_we && mem_valid;
        wb_bus.rf_waddr     = payload_q.rf_waddr;
        wb_bus.final_result = final_result;
        wb_bus.excep_en     = payload_q.excep_en;
        wb_bus.ertn_flush   = payload_q.ertn_flush;

        id_bus.load_pending = mem_valid && payload_q.res_from_mem && !ready_go;
        id_bus.rf_we        = payload_q.rf_we && mem_valid;
        id_bus.rf_waddr     = payload_q.rf_waddr;
        id_bus.final_result = final_result;

        ex_bus.excep_en     = payload_q.excep_en && mem_valid;
        ex_bus.ertn_flush   = payload_q.ertn_flush && mem_valid;
    end

    assign mem_to_wb_bus = MEM_TO_WB_W'(wb_bus);
    assign mem_to_id_bus = MEM_TO_ID_W'(id_bus);
    assign mem_to_ex_bus = MEM_TO_EX_W'(ex_bus);

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads, stalls, flush discard and reset.
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        ex_to_mem_valid;
    logic        mem_allowin;
    logic [76:0] ex_to_mem_bus;
    logic [1:0]  mem_to_ex_bus;
    logic [38:0] mem_to_id_bus;
    logic        wb_allowin;
    logic        mem_to_wb_valid;
    logic [71:0] mem_to_wb_bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        flush;

    int errors = 0;
    int checks = 0;
    int outstanding = 0;

    logic [31:0] wb_result;
    logic [31:0] wb_pc;
    logic        load_pending;

    assign wb_result    = mem_to_wb_bus[33:2];
    assign wb_pc        = mem_to_wb_bus[71:40];
    assign load_pending = mem_to_id_bus[38];

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ex_to_mem_valid   (ex_to_mem_valid),
        .mem_allowin       (mem_allowin),
        .ex_to_mem_bus     (ex_to_mem_bus),
        .mem_to_ex_bus     (mem_to_ex_bus),
        .mem_to_id_bus     (mem_to_id_bus),
        .wb_allowin        (wb_allowin),
        .mem_to_wb_valid   (mem_to_wb_valid),
        .mem_to_wb_bus     (mem_to_wb_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .flush             (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [76:0] mk_bus(input logic [31:0] pc, input logic res_mem,
                                           input logic rf_we, input logic [4:0] waddr,
                                           input logic [31:0] alu, input logic ld_b,
                                           input logic ld_h, input logic ld_u,
                                           input logic mem_req, input logic excep,
                                           input logic ertn);
        return {pc, res_mem, rf_we, waddr, alu, ld_b, ld_h, ld_u, mem_req, excep, ertn};
    endfunction

    // Response bookkeeping: a data_ok with nothing issued is a protocol violation.
    always @(negedge clk) begin
        if (reset) begin
            outstanding = 0;
        end else begin
            if (data_sram_data_ok) begin
                if (outstanding == 0) begin
                    errors++;
                    $display("FAIL protocol: data_ok with no outstanding request at %0t", $time);
                end else begin
                    outstanding--;
                end
            end
            if (ex_to_mem_valid && mem_allowin && !flush && ex_to_mem_bus[2]) outstanding++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        settle();
        if (mem_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin: got %b want 1", mem_allowin); end
        checks++;
        if (mem_to_wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b want 0", mem_to_wb_valid); end
        checks++;
        if (mem_to_wb_bus !== 72'd0) begin errors++; $display("FAIL reset_wb_bus: got %h want 0", mem_to_wb_bus); end
        checks++;
        if (mem_to_id_bus !== 39'd0) begin errors++; $display("FAIL reset_id_bus: got %h want 0", mem_to_id_bus); end
        checks++;
        if (mem_to_ex_bus !== 2'd0) begin errors++; $display("FAIL reset_ex_bus: got %b want 0", mem_to_ex_bus); end
        checks++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_ld_b();
        ex_to_mem_valid = 1'b1;
        ex_to_mem_bus   = mk_bus(32'h1C00_0000, 1'b1, 1'b1, 5'd4, 32'h0000_1003,
                                 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        settle();
        if (mem_allowin !== 1'b1) begin errors++; $display("FAIL ldb_allowin: got %b want 1", mem_allowin); end
        checks++;
        tick();
        ex_to_mem_valid = 1'b0;
        settle();
        if (mem_to_wb_valid !== 1'b0) begin errors++; $display("FAIL ldb_wait_valid: got %b want 0", mem_to_wb_valid); end
        checks++;
        if (load_pending !== 1'b1) begin errors++; $display("FAIL ldb_pending: got %b want 1", load_pending); end
        checks++;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h8011_2233;
        settle();
        if (mem_to_wb_valid !== 1'b1) begin errors++; $display("FAIL ldb_valid: got %b want 1", mem_to_wb_valid); end
        checks++;
        if (wb_result !== 32'hFFFF_FF80) begin errors++; $display("FAIL ldb_result: got %h want ffffff80", wb_result); end
        checks++;
        if (load_pending !== 1'b0) begin errors++; $display("FAIL ldb_pending_clr: got %b want 0", load_pending); end
        checks++;
        tick();
        data_sram_data_ok = 1'b0;
        settle();
        if (mem_to_wb_valid !== 1'b0) begin errors++; $display("FAIL ldb_leave: got %b want 0", mem_to_wb_valid); end
        checks++;
    endtask

    task automatic test_ld_hu();
        ex_to_mem_valid = 1'b1;
        ex_to_mem_bus   = mk_bus(32'h1C00_0004, 1'b1, 1'b1, 5'd6, 32'h0000_2002,
                                 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        ex_to_mem_valid   = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hBEEF_0000;
        settle();
        if (mem_to_wb_valid !== 1'b1) begin errors++; $display("FAIL ldhu_valid: got %b want 1", mem_to_wb_valid); end
        checks++;
        if (wb_result !== 32'h0000_BEEF) begin errors++; $display("FAIL ldhu_result: got %h want 0000beef", wb_result); end
        checks++;
        tick();
        data_sram_data_ok = 1'b0;
    endtask

    task automatic test_wb_stall();
        ex_to_mem_valid = 1'b1;
        ex_to_mem_bus   = mk_bus(32'h1C00_0008, 1'b1, 1'b1, 5'd8, 32'h0000_3000,
                                 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        ex_to_mem_valid   = 1'b0;
        wb_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1234_5678;
        settle();
        if (mem_allowin !== 1'b0) begin errors++; $display("FAIL stall_allowin0: got %b want 0", mem_allowin); end
        checks++;
        for (int i = 0; i < 3; i++) begin
            tick();
            data_sram_data_ok = 1'b0;
            data_sram_rdata   = 32'h0;
            settle();
            if (mem_allowin !== 1'b0) begin errors++; $display("FAIL stall_allowin[%0d]: got %b want 0", i, mem_allowin); end
            checks++;
            if (wb_result !== 32'h1234_5678) begin errors++; $display("FAIL stall_buf[%0d]: got %h want 12345678", i, wb_result); end
            checks++;
        end
        tick();
        wb_allowin = 1'b1;
        settle();
        if (mem_to_wb_valid !== 1'b1) begin errors++; $display("FAIL stall_release_valid: got %b want 1", mem_to_wb_valid); end
        checks++;
        if (wb_result !== 32'h1234_5678) begin errors++; $display("FAIL stall_release_data: got %h want 12345678", wb_result); end
        checks++;
        if (mem_allowin !== 1'b1) begin errors++; $display("FAIL stall_release_allowin: got %b want 1", mem_allowin); end
        checks++;
        tick();
        settle();
        if (mem_to_wb_valid !== 1'b0) begin errors++; $display("FAIL stall_leave: got %b want 0", mem_to_wb_valid); end
        checks++;
    endtask

    task automatic test_flush_discard();
        ex_to_mem_valid = 1'b1;
        ex_to_mem_bus   = mk_bus(32'h1C00_000C, 1'b1, 1'b1, 5'd3, 32'h0000_4000,
                                 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        ex_to_mem_valid = 1'b0;
        flush           = 1'b1;
        tick();
        flush = 1'b0;
        settle();
        if (mem_to_wb_valid !== 1'b0) begin errors++; $display("FAIL flush_kill: got %b want 0", mem_to_wb_valid); end
        checks++;
        if (mem_allowin !== 1'b1) begin errors++; $display("FAIL flush_allowin: got %b want 1", mem_allowin); end
        checks++;
        ex_to_mem_valid = 1'b1;
        ex_to_mem_bus   = mk_bus(32'h1C00_0010, 1'b1, 1'b1, 5'd7, 32'h0000_5000,
                                 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        ex_to_mem_valid   = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_DEAD;
        settle();
        if (mem_to_wb_valid !== 1'b0) begin errors++; $display("FAIL discard_valid: got %b want 0", mem_to_wb_valid); end
        checks++;
        if (load_pending !== 1'b1) begin errors++; $display("FAIL discard_pending: got %b want 1", load_pending); end
        checks++;
        tick();
        data_sram_rdata = 32'h0000_0055;
        settle();
        if (mem_to_wb_valid !== 1'b1) begin errors++; $display("FAIL second_valid: got %b want 1", mem_to_wb_valid); end
        checks++;
        if (wb_result !== 32'h0000_0055) begin errors++; $display("FAIL second_data: got %h want 00000055", wb_result); end
        checks++;
        tick();
        data_sram_data_ok = 1'b0;
    endtask

    task automatic test_flush_priority();
        ex_to_mem_valid = 1'b1;
        flush           = 1'b1;
        ex_to_mem_bus   = mk_bus(32'h1C00_0014, 1'b0, 1'b1, 5'd2, 32'h0000_0099,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        ex_to_mem_valid = 1'b0;
        flush           = 1'b0;
        settle();
        if (mem_to_wb_valid !== 1'b0) begin errors++; $display("FAIL prio_valid: got %b want 0", mem_to_wb_valid); end
        checks++;
        if (mem_to_id_bus[37] !== 1'b0) begin errors++; $display("FAIL prio_rf_we: got %b want 0", mem_to_id_bus[37]); end
        checks++;
    endtask

    task automatic test_alu();
        ex_to_mem_valid = 1'b1;
        ex_to_mem_bus   = mk_bus(32'h1C00_0018, 1'b0, 1'b1, 5'd5, 32'h0000_0007,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        ex_to_mem_valid = 1'b0;
        settle();
        if (mem_to_id_bus !== {1'b0, 1'b1, 5'd5, 32'd7}) begin errors++; $display("FAIL alu_id_bus: got %h want %h", mem_to_id_bus, {1'b0, 1'b1, 5'd5, 32'd7}); end
        checks++;
        if (mem_to_wb_valid !== 1'b1) begin errors++; $display("FAIL alu_valid: got %b want 1", mem_to_wb_valid); end
        checks++;
        tick();
        settle();
        if (mem_to_wb_valid !== 1'b0) begin errors++; $display("FAIL alu_leave: got %b want 0", mem_to_wb_valid); end
        checks++;
    endtask

    task automatic test_back_to_back();
        ex_to_mem_valid = 1'b1;
        ex_to_mem_bus   = mk_bus(32'h0000_0100, 1'b0, 1'b1, 5'd1, 32'h0000_0011,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        ex_to_mem_bus   = mk_bus(32'h0000_0104, 1'b0, 1'b1, 5'd2, 32'h0000_0022,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        settle();
        if (mem_allowin !== 1'b1) begin errors++; $display("FAIL b2b_allowin: got %b want 1", mem_allowin); end
        checks++;
        if (wb_result !== 32'h0000_0011) begin errors++; $display("FAIL b2b_first: got %h want 00000011", wb_result); end
        checks++;
        tick();
        ex_to_mem_valid = 1'b0;
        settle();
        if (wb_result !== 32'h0000_0022) begin errors++; $display("FAIL b2b_second: got %h want 00000022", wb_result); end
        checks++;
        if (wb_pc !== 32'h0000_0104) begin errors++; $display("FAIL b2b_pc: got %h want 00000104", wb_pc); end
        checks++;
        if (mem_to_ex_bus !== 2'b10) begin errors++; $display("FAIL b2b_excep: got %b want 10", mem_to_ex_bus); end
        checks++;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        settle();
        if (mem_to_ex_bus !== 2'b00) begin errors++; $display("FAIL b2b_excep_clr: got %b want 00", mem_to_ex_bus); end
        checks++;
    endtask

    task automatic test_reset_mid_wait();
        ex_to_mem_valid = 1'b1;
        ex_to_mem_bus   = mk_bus(32'h1C00_0020, 1'b1, 1'b1, 5'd10, 32'h0000_6000,
                                 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        ex_to_mem_valid = 1'b0;
        flush           = 1'b1;
        tick();
        flush           = 1'b0;
        ex_to_mem_valid = 1'b1;
        ex_to_mem_bus   = mk_bus(32'h1C00_0024, 1'b1, 1'b1, 5'd11, 32'h0000_6004,
                                 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        ex_to_mem_valid = 1'b0;
        reset           = 1'b1;
        tick();
        settle();
        if (mem_allowin !== 1'b1) begin errors++; $display("FAIL rst_wait_allowin: got %b want 1", mem_allowin); end
        checks++;
        if (mem_to_wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wait_valid: got %b want 0", mem_to_wb_valid); end
        checks++;
        if (mem_to_wb_bus !== 72'd0) begin errors++; $display("FAIL rst_wait_wb_bus: got %h want 0", mem_to_wb_bus); end
        checks++;
        if (mem_to_id_bus !== 39'd0) begin errors++; $display("FAIL rst_wait_id_bus: got %h want 0", mem_to_id_bus); end
        checks++;
        reset           = 1'b0;
        ex_to_mem_valid = 1'b1;
        ex_to_mem_bus   = mk_bus(32'h1C00_0028, 1'b1, 1'b1, 5'd9, 32'h0000_7000,
                                 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        ex_to_mem_valid   = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_0077;
        settle();
        if (mem_to_wb_valid !== 1'b1) begin errors++; $display("FAIL rst_cnt_clear_valid: got %b want 1", mem_to_wb_valid); end
        checks++;
        if (wb_result !== 32'h0000_0077) begin errors++; $display("FAIL rst_cnt_clear_data: got %h want 00000077", wb_result); end
        checks++;
        tick();
        data_sram_data_ok = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        ex_to_mem_valid   = 1'b0;
        ex_to_mem_bus     = '0;
        wb_allowin        = 1'b1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        flush             = 1'b0;

        test_reset();
        test_ld_b();
        test_ld_hu();
        test_wb_stall();
        test_flush_discard();
        test_flush_priority();
        test_alu();
        test_back_to_back();
        test_reset_mid_wait();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
